// File: rtl/sdram_mem_arbiter.sv
// sdram_mem_arbiter: round-robin N-port arbiter for one SDRAM port with locked write bursts
// and an outstanding-read table that routes address-tagged read beats back to their owner.
module sdram_mem_arbiter #(
   parameter int NUM_PORTS       = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 64,
   parameter int BURST_LEN       = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS-1:0]            req_read,
   input  logic [NUM_PORTS-1:0]            req_write,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic [ADDR_WIDTH-1:0]           rsp_raddr,
   output logic [NUM_PORTS-1:0]            rsp_rvalid,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic                            mem_read,
   output logic                            mem_write,
   output logic [DATA_WIDTH-1:0]           mem_wdata,
   input  logic                            mem_ready,
   input  logic [DATA_WIDTH-1:0]           mem_rdata,
   input  logic [ADDR_WIDTH-1:0]           mem_raddr,
   input  logic                            mem_rvalid,
   output logic                            err_unmatched
);
   localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
   localparam int TW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

   typedef enum logic {IDLE, WBURST} state_t;
   state_t state;
   logic [PW-1:0] rr, lock_port, gnt, nxt;
   logic [ADDR_WIDTH-1:0] lock_addr, gnt_addr;
   logic [CW-1:0] beat;
   logic [MAX_OUTSTANDING-1:0] tv;
   logic [ADDR_WIDTH-1:0] ta [MAX_OUTSTANDING];
   logic [PW-1:0] tp [MAX_OUTSTANDING];
   logic [CW-1:0] tc [MAX_OUTSTANDING];
   logic [NUM_PORTS-1:0] rd_ok, elig;
   logic gnt_vld, gnt_wr, xfer, hit;
   logic [TW-1:0] hit_idx, free_idx;

   // A read may only issue when a slot is free and its address is not already in flight,
   // so every returning raddr identifies exactly one owner.
   always_comb begin
      rd_ok = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         rd_ok[p] = ~&tv;
         for (int e = 0; e < MAX_OUTSTANDING; e++)
            if (tv[e] && ta[e] == req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]) rd_ok[p] = 1'b0;
      end
   end

   always_comb begin
      elig = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         elig[p] = state == WBURST ? req_write[p] && PW'(p) == lock_port
                                   : req_write[p] | (req_read[p] & rd_ok[p]);
   end

   always_comb begin
      gnt_vld = 1'b0;
      gnt = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--)
         if (rst && elig[PW'((int'(rr) + k) % NUM_PORTS)]) begin
            gnt_vld = 1'b1;
            gnt = PW'((int'(rr) + k) % NUM_PORTS);
         end
   end

   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      free_idx = '0;
      for (int e = MAX_OUTSTANDING - 1; e >= 0; e--) begin
         if (!tv[e]) free_idx = TW'(e);
         if (tv[e] && ta[e] == mem_raddr) begin
            hit = 1'b1;
            hit_idx = TW'(e);
         end
      end
   end

   assign gnt_wr    = req_write[gnt];
   assign gnt_addr  = req_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
   assign nxt       = gnt == PW'(NUM_PORTS - 1) ? '0 : gnt + 1'b1;
   assign xfer      = gnt_vld & mem_ready;
   assign mem_write = gnt_vld & gnt_wr;
   assign mem_read  = gnt_vld & ~gnt_wr;
   assign mem_addr  = !gnt_vld ? '0 : state == WBURST ? lock_addr : gnt_addr;
   assign mem_wdata = mem_write ? req_wdata[gnt*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign req_ready = xfer ? NUM_PORTS'(1) << gnt : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         rr <= '0;
         lock_port <= '0;
         lock_addr <= '0;
         beat <= '0;
         tv <= '0;
         rsp_rvalid <= '0;
         rsp_rdata <= '0;
         rsp_raddr <= '0;
         err_unmatched <= 1'b0;
         for (int e = 0; e < MAX_OUTSTANDING; e++) begin
            ta[e] <= '0;
            tp[e] <= '0;
            tc[e] <= '0;
         end
      end else begin
         rsp_rvalid <= '0;
         if (xfer && gnt_wr) begin
            if (state == IDLE) begin
               lock_port <= gnt;
               lock_addr <= gnt_addr;
            end
            if (beat == LAST) begin
               state <= IDLE;
               beat <= '0;
               rr <= nxt;
            end else begin
               state <= WBURST;
               beat <= beat + 1'b1;
            end
         end
         if (xfer && !gnt_wr) begin
            rr <= nxt;
            tv[free_idx] <= 1'b1;
            ta[free_idx] <= gnt_addr;
            tp[free_idx] <= gnt;
            tc[free_idx] <= '0;
         end
         // Free and allocate never touch the same slot: allocation only picks an invalid one.
         if (mem_rvalid) begin
            if (hit) begin
               rsp_rvalid <= NUM_PORTS'(1) << tp[hit_idx];
               rsp_rdata <= mem_rdata;
               rsp_raddr <= mem_raddr;
               tc[hit_idx] <= tc[hit_idx] + 1'b1;
               if (tc[hit_idx] == LAST) tv[hit_idx] <= 1'b0;
            end else begin
               err_unmatched <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_sdram_mem_arbiter.sv
// tb_sdram_mem_arbiter: directed vectors for the 2-port SDRAM arbiter with hand-computed results.
module tb_sdram_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [63:0] req_addr;
   logic [1:0] req_read, req_write, req_ready, rsp_rvalid;
   logic [127:0] req_wdata;
   logic [63:0] rsp_rdata, mem_wdata, mem_rdata;
   logic [31:0] rsp_raddr, mem_addr, mem_raddr;
   logic mem_read, mem_write, mem_ready, mem_rvalid, err_unmatched;
   int n_tests = 0;
   int n_fail = 0;

   sdram_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .req_addr(req_addr), .req_read(req_read), .req_write(req_write), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_rdata(rsp_rdata), .rsp_raddr(rsp_raddr), .rsp_rvalid(rsp_rvalid),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_raddr(mem_raddr), .mem_rvalid(mem_rvalid),
      .err_unmatched(err_unmatched)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_in();
      req_addr = '0;
      req_read = '0;
      req_write = '0;
      req_wdata = '0;
      mem_ready = 1'b1;
      mem_rdata = '0;
      mem_raddr = '0;
      mem_rvalid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_in();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One read beat from memory; er is the req_ready expected while it is presented,
   // ev the routed rsp_rvalid expected one cycle later.
   task automatic rbeat(input logic [31:0] a, input logic [63:0] d, input logic [1:0] ev, input logic [1:0] er);
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_raddr = a;
      mem_rdata = d;
      #1 check("rdy_during_beat", req_ready, er);
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1 check("rsp_rvalid", rsp_rvalid, ev);
      if (ev != 2'b00) begin
         check("rsp_rdata", rsp_rdata, d);
         check("rsp_raddr", rsp_raddr, a);
      end
   endtask

   task automatic all_zero(input string tag);
      check({tag, "_ready"}, req_ready, 0);
      check({tag, "_rvalid"}, rsp_rvalid, 0);
      check({tag, "_mread"}, mem_read, 0);
      check({tag, "_mwrite"}, mem_write, 0);
      check({tag, "_maddr"}, mem_addr, 0);
      check({tag, "_mwdata"}, mem_wdata, 0);
      check({tag, "_err"}, err_unmatched, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_in();
      #1 rst = 1'b0;
      #2 all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // single read, 4 beats routed to P0, then table free again
      @(negedge clk);
      req_read = 2'b01;
      req_addr[31:0] = 32'h100;
      #1 check("t1_ready", req_ready, 2'b01);
      check("t1_mread", mem_read, 1);
      check("t1_maddr", mem_addr, 32'h100);
      @(negedge clk);
      #1 check("t1_dup_blocked", req_ready, 2'b00);
      req_read = 2'b00;
      for (int k = 0; k < 4; k++) rbeat(32'h100, 64'hA0 + 64'(k), 2'b01, 2'b00);
      @(negedge clk);
      req_read = 2'b01;
      #1 check("t1_table_free", req_ready, 2'b01);

      // both ports read: P0 first, then P1; interleaved responses
      do_reset();
      @(negedge clk);
      req_read = 2'b11;
      req_addr[31:0] = 32'h100;
      req_addr[63:32] = 32'h200;
      #1 check("t2_gnt_p0", req_ready, 2'b01);
      @(negedge clk);
      req_read = 2'b10;
      #1 check("t2_gnt_p1", req_ready, 2'b10);
      check("t2_maddr", mem_addr, 32'h200);
      @(negedge clk);
      req_read = 2'b00;
      rbeat(32'h200, 64'hB0, 2'b10, 2'b00);
      rbeat(32'h200, 64'hB1, 2'b10, 2'b00);
      rbeat(32'h100, 64'hC0, 2'b01, 2'b00);
      rbeat(32'h100, 64'hC1, 2'b01, 2'b00);
      rbeat(32'h200, 64'hB2, 2'b10, 2'b00);
      rbeat(32'h200, 64'hB3, 2'b10, 2'b00);
      rbeat(32'h100, 64'hC2, 2'b01, 2'b00);
      rbeat(32'h100, 64'hC3, 2'b01, 2'b00);
      check("t2_no_err", err_unmatched, 0);

      // P1 write burst with a stall beat; P0 read blocked until the burst ends
      do_reset();
      @(negedge clk);
      req_write = 2'b10;
      req_addr[63:32] = 32'h300;
      req_wdata[127:64] = 64'hD0;
      #1 check("t3_b0_ready", req_ready, 2'b10);
      check("t3_b0_mwrite", mem_write, 1);
      check("t3_b0_maddr", mem_addr, 32'h300);
      check("t3_b0_wdata", mem_wdata, 64'hD0);
      @(negedge clk);
      req_read = 2'b01;
      req_addr[31:0] = 32'h400;
      req_addr[63:32] = 32'h3F0;
      req_wdata[127:64] = 64'hD1;
      mem_ready = 1'b0;
      #1 check("t3_stall_ready", req_ready, 2'b00);
      check("t3_stall_maddr", mem_addr, 32'h300);
      check("t3_stall_mread", mem_read, 0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         mem_ready = 1'b1;
         req_wdata[127:64] = 64'hD0 + 64'(k);
         #1 check("t3_beat_ready", req_ready, 2'b10);
         check("t3_beat_maddr", mem_addr, 32'h300);
         check("t3_beat_wdata", mem_wdata, 64'hD0 + 64'(k));
      end
      @(negedge clk);
      req_write = 2'b00;
      #1 check("t3_p0_ready", req_ready, 2'b01);
      check("t3_p0_maddr", mem_addr, 32'h400);
      check("t3_p0_mwrite", mem_write, 0);

      // table full: 5th read waits for a free, accepted the cycle after
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         req_read = 2'b01;
         req_addr[31:0] = 32'h10 * 32'(k);
         #1 check("t4_fill_ready", req_ready, 2'b01);
      end
      @(negedge clk);
      req_addr[31:0] = 32'h50;
      #1 check("t4_full_ready", req_ready, 2'b00);
      for (int k = 0; k < 4; k++) rbeat(32'h20, 64'hE0 + 64'(k), 2'b01, 2'b00);
      check("t4_after_free", req_ready, 2'b01);

      // same address outstanding on P0 blocks P1
      do_reset();
      @(negedge clk);
      req_read = 2'b01;
      req_addr[31:0] = 32'h100;
      #1 check("t5_p0_ready", req_ready, 2'b01);
      @(negedge clk);
      req_read = 2'b10;
      req_addr[63:32] = 32'h100;
      #1 check("t5_p1_blocked", req_ready, 2'b00);
      for (int k = 0; k < 4; k++) rbeat(32'h100, 64'hF0 + 64'(k), 2'b01, 2'b00);
      check("t5_p1_ready", req_ready, 2'b10);

      // unmatched beat, then async reset in the middle of a write burst
      do_reset();
      rbeat(32'hDEAD, 64'h1, 2'b00, 2'b00);
      check("t6_err_set", err_unmatched, 1);
      @(negedge clk);
      req_write = 2'b10;
      req_addr[63:32] = 32'h300;
      req_wdata[127:64] = 64'h77;
      #1 check("t6_wr_ready", req_ready, 2'b10);
      @(negedge clk);
      #1 check("t6_wr_mid", mem_write, 1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 all_zero("t6_async");
      @(negedge clk);
      rst = 1'b1;
      req_write = 2'b00;
      req_read = 2'b01;
      req_addr[31:0] = 32'h500;
      #1 check("t6_unlocked", req_ready, 2'b01);
      check("t6_err_clear", err_unmatched, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
